// File: rtl/slave_axi_rd_responder.sv
// AXI4 read-slave front end of the AXI2APB bridge: queues AR requests, expands each
// burst into per-beat engine commands and returns engine data on the R channel.
module slave_axi_rd_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int AR_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [LEN_WIDTH-1:0]  arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  cmd_valid,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_ready,
    input  logic                  dat_valid,
    input  logic [DATA_WIDTH-1:0] dat_data,
    input  logic                  dat_err,
    output logic                  dat_ready
);
    localparam int PTR_W      = $clog2(AR_DEPTH);
    localparam int ENT_W      = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size,
                                           input logic [LEN_WIDTH-1:0] len);
        logic size_bad;
        logic wrap_bad;
        size_bad = (32'd1 << size) > 32'(BEAT_BYTES);
        wrap_bad = (burst == 2'b10) && !((len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                                         (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15)));
        return (burst == 2'b11) || size_bad || wrap_bad;
    endfunction

    // WRAP keeps the upper address bits and lets only the bits inside the window roll over.
    function automatic logic [ADDR_WIDTH-1:0] beat_next(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [LEN_WIDTH-1:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] nxt;
        bytes = ADDR_WIDTH'(1) << size;
        mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b01:   nxt = addr + bytes;
            2'b10:   nxt = (addr & ~mask) | ((addr + bytes) & mask);
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    logic [ENT_W-1:0]      mem_q [AR_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, iss_cnt_q, iss_cnt_d, ret_cnt_q, ret_cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic [ID_WIDTH-1:0]   head_id_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [LEN_WIDTH-1:0]  head_len_s;
    logic [2:0]            head_size_s;
    logic [1:0]            head_burst_s;
    logic                  push_s, pop_s, pass_s, r_hs_s, r_end_s;

    assign {head_id_s, head_addr_s, head_len_s, head_size_s, head_burst_s} = mem_q[rd_ptr_q];

    assign arready = !rst && (count_q != (PTR_W + 1)'(AR_DEPTH));
    assign push_s  = arvalid && arready;
    assign pop_s   = (state_q == S_IDLE) && (count_q != '0);

    // In ISSUE/DRAIN the R channel is wired straight through to the engine return path.
    assign pass_s    = !rst && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign cmd_valid = !rst && (state_q == S_ISSUE);
    assign cmd_addr  = cmd_valid ? addr_q : '0;
    assign rvalid    = pass_s ? dat_valid : (!rst && (state_q == S_ERR));
    assign dat_ready = pass_s && rready;
    assign rdata     = pass_s ? dat_data : '0;
    assign rresp     = ((pass_s && dat_err) || (!rst && (state_q == S_ERR))) ? 2'b10 : 2'b00;
    assign rlast     = rvalid && (ret_cnt_q == len_q);
    assign rid       = rst ? '0 : id_q;
    assign r_hs_s    = rvalid && rready;
    assign r_end_s   = r_hs_s && rlast;

    // Queue pointers/occupancy and burst FSM next-state logic.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    id_d      = head_id_s;
                    addr_d    = head_addr_s;
                    len_d     = head_len_s;
                    size_d    = head_size_s;
                    burst_d   = head_burst_s;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    state_d   = burst_illegal(head_burst_s, head_size_s, head_len_s) ? S_ERR : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    addr_d    = beat_next(addr_q, size_q, len_q, burst_q);
                    iss_cnt_d = iss_cnt_q + LEN_WIDTH'(1);
                    state_d   = (iss_cnt_q == len_q) ? S_DRAIN : S_ISSUE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: state_d = S_DRAIN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Returned beats may overlap issue, so the R counter runs in every non-idle state.
        if (r_hs_s) begin
            if (r_end_s) begin
                ret_cnt_d = '0;
                state_d   = S_IDLE;
            end else begin
                ret_cnt_d = ret_cnt_q + LEN_WIDTH'(1);
            end
        end else begin
            ret_cnt_d = ret_cnt_q;
        end
    end

    // State, pointer and burst registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // AR queue storage; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {arid, araddr, arlen, arsize, arburst};
        end
    end
endmodule

// File: tb/tb_slave_axi_rd_responder.sv
// Self-checking bench for slave_axi_rd_responder: a randomised engine and R sink around
// the DUT, checked against a burst-level model of the expected commands and R beats.
module tb_slave_axi_rd_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic        dat_valid, dat_err, dat_ready;
    logic [31:0] dat_data;

    always #5 clk = ~clk;

    slave_axi_rd_responder dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .dat_valid(dat_valid), .dat_data(dat_data), .dat_err(dat_err), .dat_ready(dat_ready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic [31:0] exp_cmd[$];
    rbeat_t      exp_r[$];
    logic [31:0] pend[$];
    logic        pend_err[$];
    int checks = 0, errors = 0;
    int cmd_cnt = 0, model_cmd_idx = 0, err_idx = -1;
    int cmd_seen = 0, r_seen = 0, last_seen = 0, err_seen = 0;
    int cr_mode = 1, rr_mode = 1, dv_mode = 1;
    logic [31:0] mon_exp_addr;
    rbeat_t      mon_got, mon_exp;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F;
    endfunction

    // Burst-level reference: list every beat address and R beat the burst should produce.
    function automatic void model_add(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] bytes, window, base, a;
        logic illegal;
        rbeat_t b;
        bytes   = 32'd1 << size;
        window  = (32'(len) + 32'd1) * bytes;
        illegal = (burst == 2'b11) || (bytes > 32'd4) ||
                  ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.last = (i == int'(len));
            if (illegal) begin
                b.data = 32'd0;
                b.resp = 2'b10;
            end else begin
                case (burst)
                    2'b00:   a = addr;
                    2'b01:   a = addr + 32'(i) * bytes;
                    default: begin
                        base = addr - (addr % window);
                        a    = base + ((addr % window) + 32'(i) * bytes) % window;
                    end
                endcase
                exp_cmd.push_back(a);
                b.data = mem_data(a);
                b.resp = (model_cmd_idx == err_idx) ? 2'b10 : 2'b00;
                model_cmd_idx++;
            end
            exp_r.push_back(b);
        end
    endfunction

    // Engine model, R sink and scoreboard: drive on negedge, sample 1 ns later.
    initial begin
        forever begin
            @(negedge clk);
            case (cr_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (rr_mode)
                1:       rready = 1'b1;
                2:       rready = ($urandom_range(0, 2) != 0);
                default: rready = ~rready;
            endcase
            if (pend.size() > 0 && (dv_mode == 1 || $urandom_range(0, 2) != 0)) begin
                dat_valid = 1'b1;
                dat_data  = mem_data(pend[0]);
                dat_err   = pend_err[0];
            end else begin
                dat_valid = 1'b0;
                dat_data  = $urandom;
                dat_err   = 1'($urandom_range(0, 1));
            end
            #1;
            if (rst) begin
                pend.delete();
                pend_err.delete();
            end else begin
                if (cmd_valid && cmd_ready) begin
                    pend.push_back(cmd_addr);
                    pend_err.push_back(cmd_cnt == err_idx);
                    cmd_cnt++;
                    cmd_seen++;
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_addr got %h required no command", cmd_addr);
                    end else begin
                        mon_exp_addr = exp_cmd.pop_front();
                        if (cmd_addr !== mon_exp_addr) begin
                            errors++;
                            $display("FAIL cmd_addr got %h required %h", cmd_addr, mon_exp_addr);
                        end
                    end
                end
                if (dat_valid && dat_ready) begin
                    void'(pend.pop_front());
                    void'(pend_err.pop_front());
                end
                if (rvalid && rready) begin
                    mon_got = '{id: rid, data: rdata, resp: rresp, last: rlast};
                    r_seen++;
                    if (rlast) last_seen++;
                    if (rresp == 2'b10) err_seen++;
                    checks++;
                    if (exp_r.size() == 0) begin
                        errors++;
                        $display("FAIL r_beat got id=%h data=%h resp=%b last=%b required no beat",
                                 rid, rdata, rresp, rlast);
                    end else begin
                        mon_exp = exp_r.pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL r_beat got id=%h data=%h resp=%b last=%b required id=%h data=%h resp=%b last=%b",
                                     rid, rdata, rresp, rlast, mon_exp.id, mon_exp.data, mon_exp.resp, mon_exp.last);
                        end
                    end
                end
            end
        end
    end

    task automatic new_test();
        cmd_seen = 0; r_seen = 0; last_seen = 0; err_seen = 0;
        cmd_cnt = 0; model_cmd_idx = 0; err_idx = -1;
    endtask

    task automatic ar_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (arready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ar_accept got arready=0 for 400 cycles required acceptance id=%h", id);
        end else begin
            @(posedge clk);
            model_add(id, addr, len, size, burst);
        end
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 4000; i++) begin
            if (exp_r.size() == 0 && exp_cmd.size() == 0) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        ok = (exp_r.size() == 0) && (exp_cmd.size() == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({arready, cmd_valid, rvalid, rlast, dat_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000", {arready, cmd_valid, rvalid, rlast, dat_ready});
        end
        checks++;
        if ({rid, rdata, rresp, cmd_addr} !== 70'd0) begin
            errors++;
            $display("FAIL reset_data got rid=%h rdata=%h rresp=%b cmd_addr=%h required 0", rid, rdata, rresp, cmd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if ({arready, cmd_valid, rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset got arready/cmd_valid/rvalid=%b required 100", {arready, cmd_valid, rvalid});
        end
    endtask

    task automatic test_incr();
        bit ok;
        new_test(); cr_mode = 1; rr_mode = 1; dv_mode = 1;
        ar_push(4'h1, 32'h100, 8'd3, 3'd2, 2'b01);
        wait_done(ok);
        checks++;
        if (!ok || cmd_seen != 4 || r_seen != 4 || last_seen != 1 || err_seen != 0) begin
            errors++;
            $display("FAIL incr got done=%0d cmds=%0d beats=%0d lasts=%0d errs=%0d required 1 4 4 1 0",
                     ok, cmd_seen, r_seen, last_seen, err_seen);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        new_test(); cr_mode = 2; rr_mode = 1; dv_mode = 2;
        ar_push(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_done(ok);
        checks++;
        if (!ok || cmd_seen != 4 || r_seen != 4 || last_seen != 1) begin
            errors++;
            $display("FAIL wrap got done=%0d cmds=%0d beats=%0d lasts=%0d required 1 4 4 1",
                     ok, cmd_seen, r_seen, last_seen);
        end
    endtask

    task automatic test_fixed_err();
        bit ok;
        new_test(); cr_mode = 1; rr_mode = 1; dv_mode = 1; err_idx = 1;
        ar_push(4'h3, 32'h20, 8'd2, 3'd2, 2'b00);
        wait_done(ok);
        checks++;
        if (!ok || cmd_seen != 3 || r_seen != 3 || last_seen != 1 || err_seen != 1) begin
            errors++;
            $display("FAIL fixed_err got done=%0d cmds=%0d beats=%0d lasts=%0d errs=%0d required 1 3 3 1 1",
                     ok, cmd_seen, r_seen, last_seen, err_seen);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        new_test(); cr_mode = 1; rr_mode = 2; dv_mode = 1;
        ar_push(4'h4, 32'h40, 8'd1, 3'd2, 2'b11);
        ar_push(4'h5, 32'h80, 8'd0, 3'd3, 2'b01);
        ar_push(4'h6, 32'h00, 8'd2, 3'd2, 2'b10);
        wait_done(ok);
        checks++;
        if (!ok || cmd_seen != 0 || r_seen != 6 || last_seen != 3 || err_seen != 6) begin
            errors++;
            $display("FAIL illegal got done=%0d cmds=%0d beats=%0d lasts=%0d errs=%0d required 1 0 6 3 6",
                     ok, cmd_seen, r_seen, last_seen, err_seen);
        end
    endtask

    task automatic test_queue_full();
        bit ok;
        new_test(); cr_mode = 0; rr_mode = 1; dv_mode = 1;
        for (int i = 0; i < 5; i++) ar_push(4'(8 + i), 32'h200 + 32'(i) * 32'h10, 8'd0, 3'd2, 2'b01);
        @(negedge clk);
        #2;
        checks++;
        if (arready !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h200) begin
            errors++;
            $display("FAIL queue_full got arready=%b cmd_valid=%b cmd_addr=%h required 0 1 00000200",
                     arready, cmd_valid, cmd_addr);
        end
        cr_mode = 1;
        wait_done(ok);
        checks++;
        if (!ok || r_seen != 5 || last_seen != 5) begin
            errors++;
            $display("FAIL queue_drain got done=%0d beats=%0d lasts=%0d required 1 5 5", ok, r_seen, last_seen);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        new_test(); cr_mode = 2; rr_mode = 3; dv_mode = 2;
        ar_push(4'hA, 32'h1000, 8'd7, 3'd2, 2'b01);
        ar_push(4'hB, 32'h2004, 8'd3, 3'd1, 2'b00);
        ar_push(4'hC, 32'h3008, 8'd7, 3'd0, 2'b10);
        wait_done(ok);
        checks++;
        if (!ok || cmd_seen != 20 || r_seen != 20 || last_seen != 3) begin
            errors++;
            $display("FAIL back_to_back got done=%0d cmds=%0d beats=%0d lasts=%0d required 1 20 20 3",
                     ok, cmd_seen, r_seen, last_seen);
        end
    endtask

    task automatic test_random();
        bit ok;
        int total;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] addr;
        new_test(); cr_mode = 2; rr_mode = 2; dv_mode = 2;
        err_idx = $urandom_range(0, 20);
        total = 0;
        for (int n = 0; n < 24; n++) begin
            burst = 2'($urandom_range(0, 3));
            size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == 2'b10) begin
                case ($urandom_range(0, 4))
                    0:       len = 8'd1;
                    1:       len = 8'd3;
                    2:       len = 8'd7;
                    3:       len = 8'd15;
                    default: len = 8'd2;
                endcase
            end else begin
                len = 8'($urandom_range(0, 7));
            end
            addr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : 32'($urandom);
            total += int'(len) + 1;
            ar_push(4'(n), addr, len, size, burst);
        end
        wait_done(ok);
        checks++;
        if (!ok || r_seen != total || last_seen != 24) begin
            errors++;
            $display("FAIL random got done=%0d beats=%0d lasts=%0d required 1 %0d 24", ok, r_seen, last_seen, total);
        end
    endtask

    task automatic test_reset_mid();
        int r_before, c_before;
        new_test(); cr_mode = 1; rr_mode = 1; dv_mode = 1;
        ar_push(4'h7, 32'h1000, 8'd15, 3'd2, 2'b01);
        ar_push(4'h8, 32'h5000, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 200 && r_seen < 3; i++) @(negedge clk);
        checks++;
        if (r_seen < 3) begin
            errors++;
            $display("FAIL reset_mid_start got beats=%0d required >=3", r_seen);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (rvalid !== 1'b0 || cmd_valid !== 1'b0 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rvalid=%b cmd_valid=%b dat_ready=%b required 0 0 0", rvalid, cmd_valid, dat_ready);
        end
        exp_cmd.delete();
        exp_r.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        r_before = r_seen;
        c_before = cmd_seen;
        repeat (12) @(negedge clk);
        checks++;
        if (r_seen != r_before || cmd_seen != c_before) begin
            errors++;
            $display("FAIL reset_mid_quiet got beats=%0d cmds=%0d required %0d %0d", r_seen, cmd_seen, r_before, c_before);
        end
    endtask

    initial begin
        rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0; cmd_ready = 1'b0; dat_valid = 1'b0; dat_data = '0; dat_err = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_err();
        test_illegal();
        test_queue_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
